// File: rtl/dot_acc_pkg.sv
// dot_acc_pkg: shared FSM state type, default widths and coefficient range for dot_acc_seq
package dot_acc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;
  localparam int SAMP_W = 9;
  localparam int COEF_W = 2;
  localparam int ACC_W = 16;
  localparam int COEF_MIN = -2;
  localparam int COEF_MAX = 1;
endpackage

// File: rtl/mac9x2_add16.sv
// mac9x2_add16: combinational signed multiply-add, sum = acc + samp*coef modulo 2^ACC_W
module mac9x2_add16 #(
  parameter int SAMP_W = dot_acc_pkg::SAMP_W,
  parameter int COEF_W = dot_acc_pkg::COEF_W,
  parameter int ACC_W = dot_acc_pkg::ACC_W
) (
  input  logic [SAMP_W-1:0] samp,
  input  logic [COEF_W-1:0] coef,
  input  logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  sum
);
  logic signed [SAMP_W+COEF_W-1:0] prod;
  assign prod = $signed(samp) * $signed(coef);
  assign sum = acc + ACC_W'(prod);
endmodule

// File: rtl/dot_acc_seq.sv
// dot_acc_seq: sequential dot-product engine with coefficient bank and valid/ready handshakes
module dot_acc_seq #(
  parameter int N_TAPS = 8,
  parameter int SAMP_W = dot_acc_pkg::SAMP_W,
  parameter int COEF_W = dot_acc_pkg::COEF_W,
  parameter int ACC_W = dot_acc_pkg::ACC_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      coef_wr_en,
  input  logic [$clog2(N_TAPS)-1:0] coef_wr_addr,
  input  logic [COEF_W-1:0]         coef_wr_data,
  input  logic [ACC_W-1:0]          bias,
  input  logic                      start,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [SAMP_W-1:0]         s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [ACC_W-1:0]          m_data,
  output logic                      busy
);
  import dot_acc_pkg::*;
  localparam int TW = $clog2(N_TAPS);
  state_e state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [TW-1:0] tap;
  logic [COEF_W-1:0] coef [N_TAPS];
  logic last;
  assign last = tap == TW'(N_TAPS - 1);
  mac9x2_add16 #(.SAMP_W(SAMP_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .samp(s_data),
    .coef(coef[tap]),
    .acc(acc),
    .sum(sum)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      tap <= '0;
      coef <= '{default: '0};
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      busy <= 1'b0;
    end else
      case (state)
        IDLE: begin
          if (coef_wr_en) coef[coef_wr_addr] <= coef_wr_data;
          if (start) begin
            acc <= bias;
            tap <= '0;
            s_ready <= 1'b1;
            busy <= 1'b1;
            state <= ACCUM;
          end
        end
        ACCUM: if (s_valid) begin
          acc <= sum;
          tap <= tap + 1'b1;
          if (last) begin
            m_data <= sum;
            m_valid <= 1'b1;
            s_ready <= 1'b0;
            state <= HOLD;
          end
        end
        HOLD: if (m_ready) begin
          m_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule
